// File: rtl/wb_queue_pkg.sv
// Shared CPU types for the write-back queue: register index/data widths and the pending entry.
package wb_queue_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;

  typedef logic [RegAddrW-1:0] regAddr_t;
  typedef logic [RegDataW-1:0] regData_t;

  typedef struct packed {
    regAddr_t addr;
    regData_t data;
  } wbEntry_t;

endpackage

// File: rtl/wb_queue_if.sv
// Request / register-file write bundle for wb_queue.
// Bypass query signals exist only when WB_QUEUE_BYPASS_EN is defined.
interface wb_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import wb_queue_pkg::*;

  logic                   in_valid;
  regAddr_t               in_addr;
  regData_t               in_data;
  logic                   in_ready;
  logic                   RegWrite;
  regAddr_t               WriteAddr;
  regData_t               WriteData;
  logic [$clog2(DEPTH):0] count;
`ifdef WB_QUEUE_BYPASS_EN
  regAddr_t               RsAddr;
  regAddr_t               RtAddr;
  logic                   RsHit;
  logic                   RtHit;
  regData_t               RsFwd;
  regData_t               RtFwd;
`endif

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, RegWrite, WriteAddr, WriteData, count
`ifdef WB_QUEUE_BYPASS_EN
    ,
    output RsAddr, RtAddr,
    input  RsHit, RtHit, RsFwd, RtFwd
`endif
  );

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, RegWrite, WriteAddr, WriteData, count
`ifdef WB_QUEUE_BYPASS_EN
    ,
    input  RsAddr, RtAddr,
    output RsHit, RtHit, RsFwd, RtFwd
`endif
  );

endinterface

// File: rtl/wb_match.sv
// Youngest-match search over pending entries supplied oldest-first (index 0 = head).
module wb_match
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wbEntry_t [DEPTH-1:0] entries,
  input  logic     [DEPTH-1:0] valid,
  input  regAddr_t             query,
  output logic                 hit,
  output regData_t             fwd
);

  // Later (younger) matches overwrite earlier ones; register 0 is never pending.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i] && (query != '0) && (entries[i].addr == query)) begin
        hit = 1'b1;
        fwd = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/wb_queue.sv
// Pending register-write queue: accepts writes, retires one per cycle in order.
// Optional forwarding of pending data to Rs/Rt queries under WB_QUEUE_BYPASS_EN.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  wb_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wbEntry_t          mem [DEPTH];
  logic [PtrW-1:0]   wrPtrQ, wrPtrD;
  logic [PtrW-1:0]   rdPtrQ, rdPtrD;
  logic [CntW-1:0]   countQ, countD;
  logic              inReady;
  logic              push;
  logic              pop;

  assign inReady = (countQ != CntW'(DEPTH));
  // Writes to register 0 are acknowledged but never stored.
  assign push    = bus.in_valid && inReady && (bus.in_addr != '0);
  assign pop     = (countQ != '0);

  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (push) begin
      wrPtrD = wrPtrQ + 1'b1;
    end
    if (pop) begin
      rdPtrD = rdPtrQ + 1'b1;
    end
    case ({push, pop})
      2'b10:   countD = countQ + 1'b1;
      2'b01:   countD = countQ - 1'b1;
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtrQ] <= '{addr: bus.in_addr, data: bus.in_data};
    end
  end

  always_comb begin
    bus.in_ready  = inReady;
    bus.count     = countQ;
    bus.RegWrite  = 1'b0;
    bus.WriteAddr = '0;
    bus.WriteData = '0;
    if (pop) begin
      bus.RegWrite  = 1'b1;
      bus.WriteAddr = mem[rdPtrQ].addr;
      bus.WriteData = mem[rdPtrQ].data;
    end
  end

`ifdef WB_QUEUE_BYPASS_EN
  wbEntry_t [DEPTH-1:0] ageOrd;
  logic     [DEPTH-1:0] ageVld;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ageOrd[i] = mem[rdPtrQ + PtrW'(i)];
      ageVld[i] = (CntW'(i) < countQ);
    end
  end

  wb_match #(
    .DEPTH (DEPTH)
  ) u_rs_match (
    .entries (ageOrd),
    .valid   (ageVld),
    .query   (bus.RsAddr),
    .hit     (bus.RsHit),
    .fwd     (bus.RsFwd)
  );

  wb_match #(
    .DEPTH (DEPTH)
  ) u_rt_match (
    .entries (ageOrd),
    .valid   (ageVld),
    .query   (bus.RtAddr),
    .hit     (bus.RtHit),
    .fwd     (bus.RtFwd)
  );
`endif

endmodule
